// File: rtl/mesi_isc_pkg.sv
// Shared encodings and widths for the MESI intersection controller.
// Command and broadcast-type codes are fixed 3- and 2-bit values.
package mesi_isc_pkg;

    localparam int CBUS_CMD_W   = 3;
    localparam int BROAD_TYPE_W = 2;
    localparam int BROAD_ID_W   = 5;
    localparam int NUM_CPU      = 4;

    localparam logic [2:0] CBUS_CMD_NOP      = 3'd0;
    localparam logic [2:0] CBUS_CMD_WR       = 3'd1;
    localparam logic [2:0] CBUS_CMD_RD       = 3'd2;
    localparam logic [2:0] CBUS_CMD_WR_BROAD = 3'd3;
    localparam logic [2:0] CBUS_CMD_RD_BROAD = 3'd4;

    localparam logic [1:0] BROAD_TYPE_WR = 2'd1;
    localparam logic [1:0] BROAD_TYPE_RD = 2'd2;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_HOLD
    } arb_state_t;

endpackage

// File: rtl/mesi_isc_breq_rr.sv
// Combinational 4-way round-robin selector.
// Search starts at ptr and wraps; lowest offset from ptr wins.
module mesi_isc_breq_rr (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] grant,
    output logic [1:0] idx,
    output logic       valid
);

    logic [1:0] cand;

    always_comb begin
        cand  = ptr;
        idx   = ptr;
        valid = 1'b0;
        // Walk from the farthest offset down so the nearest one sticks.
        for (int i = 3; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (req[cand]) begin
                idx   = cand;
                valid = 1'b1;
            end
        end
        grant = valid ? (4'b0001 << idx) : 4'b0000;
    end

endmodule

// File: rtl/mesi_isc_breq_arb.sv
// Broadcast request arbiter: grants one CPU broadcast at a time,
// writes it to the broadcast FIFO and holds until the CPU drops it.
module mesi_isc_breq_arb
    import mesi_isc_pkg::*;
#(
    parameter int CBUS_CMD_WIDTH   = CBUS_CMD_W,
    parameter int BROAD_TYPE_WIDTH = BROAD_TYPE_W,
    parameter int BROAD_ID_WIDTH   = BROAD_ID_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [4*CBUS_CMD_WIDTH-1:0] mbus_cmd_array_i,
    input  logic                        fifo_status_full_i,
    output logic [3:0]                  mbus_ack_array_o,
    output logic                        broad_fifo_wr_o,
    output logic [BROAD_TYPE_WIDTH-1:0] broad_type_o,
    output logic [1:0]                  broad_cpu_id_o,
    output logic [BROAD_ID_WIDTH-1:0]   broad_id_o
);

    logic [CBUS_CMD_WIDTH-1:0] cmd [NUM_CPU];
    logic [3:0]                req;

    arb_state_t                state_q, state_d;
    logic [1:0]                ptr_q, ptr_d;
    logic [BROAD_ID_WIDTH-1:0] cnt_q, cnt_d;
    logic [BROAD_ID_WIDTH-1:0] bid_q, bid_d;
    logic [BROAD_TYPE_WIDTH-1:0] typ_q, typ_d;
    logic [1:0]                cpu_q, cpu_d;
    logic                      wr_q, wr_d;
    logic [3:0]                ack_q, ack_d;

    logic [3:0]                gnt;
    logic [1:0]                gidx;
    logic                      gvld;

    always_comb begin
        for (int i = 0; i < NUM_CPU; i++) begin
            cmd[i] = mbus_cmd_array_i[i*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH];
            req[i] = (cmd[i] == CBUS_CMD_WIDTH'(CBUS_CMD_WR_BROAD)) ||
                     (cmd[i] == CBUS_CMD_WIDTH'(CBUS_CMD_RD_BROAD));
        end
    end

    mesi_isc_breq_rr u_rr (
        .req   (req),
        .ptr   (ptr_q),
        .grant (gnt),
        .idx   (gidx),
        .valid (gvld)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        bid_d   = bid_q;
        typ_d   = typ_q;
        cpu_d   = cpu_q;
        wr_d    = 1'b0;
        ack_d   = 4'b0000;
        unique case (state_q)
            ARB_IDLE: begin
                if (gvld && !fifo_status_full_i) begin
                    state_d = ARB_ISSUE;
                    wr_d    = 1'b1;
                    ack_d   = gnt;
                    cpu_d   = gidx;
                    ptr_d   = gidx + 2'd1;
                    bid_d   = cnt_q;
                    typ_d   = (cmd[gidx] == CBUS_CMD_WIDTH'(CBUS_CMD_WR_BROAD))
                              ? BROAD_TYPE_WIDTH'(BROAD_TYPE_WR)
                              : BROAD_TYPE_WIDTH'(BROAD_TYPE_RD);
                end
            end
            ARB_ISSUE: begin
                state_d = ARB_HOLD;
                cnt_d   = cnt_q + BROAD_ID_WIDTH'(1);
            end
            ARB_HOLD: begin
                if (!req[cpu_q]) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Outputs are registered so ISSUE values appear the cycle after the grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            bid_q   <= '0;
            typ_q   <= '0;
            cpu_q   <= '0;
            wr_q    <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            bid_q   <= bid_d;
            typ_q   <= typ_d;
            cpu_q   <= cpu_d;
            wr_q    <= wr_d;
            ack_q   <= ack_d;
        end
    end

    assign mbus_ack_array_o = ack_q;
    assign broad_fifo_wr_o  = wr_q;
    assign broad_type_o     = typ_q;
    assign broad_cpu_id_o   = cpu_q;
    assign broad_id_o       = bid_q;

endmodule

// File: tb/tb_mesi_isc_breq_arb.sv
// Directed bench for the broadcast request arbiter.
// Vector table plus hand-written multi-cycle sequences.
module tb_mesi_isc_breq_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  cmd [4];
    logic [11:0] mbus_cmd;
    logic        full;
    logic [3:0]  ack;
    logic        wr;
    logic [1:0]  typ;
    logic [1:0]  cpu;
    logic [4:0]  bid;

    int vecs = 0;
    int miss = 0;

    assign mbus_cmd = {cmd[3], cmd[2], cmd[1], cmd[0]};

    always #5 clk = ~clk;

    mesi_isc_breq_arb dut (
        .clk                (clk),
        .rst                (rst),
        .mbus_cmd_array_i   (mbus_cmd),
        .fifo_status_full_i (full),
        .mbus_ack_array_o   (ack),
        .broad_fifo_wr_o    (wr),
        .broad_type_o       (typ),
        .broad_cpu_id_o     (cpu),
        .broad_id_o         (bid)
    );

    typedef struct {
        logic [2:0] c0, c1, c2, c3;
        logic       full;
        logic       wr;
        logic [3:0] ack;
        logic [1:0] typ;
        logic [1:0] cpu;
        logic [4:0] id;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string nm, input logic e_wr,
                       input logic [3:0] e_ack, input logic [1:0] e_typ,
                       input logic [1:0] e_cpu, input logic [4:0] e_id);
        vecs++;
        if (wr !== e_wr || ack !== e_ack || typ !== e_typ ||
            cpu !== e_cpu || bid !== e_id) begin
            miss++;
            $display("FAIL %s: got wr=%b ack=%b type=%0d cpu=%0d id=%0d, want wr=%b ack=%b type=%0d cpu=%0d id=%0d",
                     nm, wr, ack, typ, cpu, bid, e_wr, e_ack, e_typ, e_cpu, e_id);
        end
    endtask

    task automatic chk_quiet(input string nm);
        vecs++;
        if (wr !== 1'b0 || ack !== 4'b0000) begin
            miss++;
            $display("FAIL %s: got wr=%b ack=%b, want wr=0 ack=0000",
                     nm, wr, ack);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_wr(input string nm, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (wr === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
        vecs++;
        miss++;
        $display("FAIL %s: got no write within 10 cycles, want a write", nm);
    endtask

    // Wait for a grant, check it, let the CPU drop, then re-request.
    task automatic grant(input string nm, input int k, input logic [1:0] e_typ,
                         input logic [4:0] e_id, input logic [2:0] again);
        bit ok;
        wait_wr(nm, ok);
        if (ok) chk(nm, 1'b1, 4'b0001 << k, e_typ, 2'(k), e_id);
        cmd[k] = 3'd0;
        tick();
        tick();
        cmd[k] = again;
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b0;
        #1;
        chk(nm, 1'b0, 4'b0000, 2'd0, 2'd0, 5'd0);
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        bit ok;
        for (int i = 0; i < 4; i++) cmd[i] = 3'd0;
        full = 1'b0;

        tbl[0]  = '{0,0,0,0, 0, 0,4'b0000,2'd0,2'd0,5'd0};
        tbl[1]  = '{0,0,4,0, 0, 1,4'b0100,2'd2,2'd2,5'd0};
        tbl[2]  = '{0,0,4,0, 0, 0,4'b0000,2'd2,2'd2,5'd0};
        tbl[3]  = '{0,0,4,0, 0, 0,4'b0000,2'd2,2'd2,5'd0};
        tbl[4]  = '{0,0,0,0, 0, 0,4'b0000,2'd2,2'd2,5'd0};
        tbl[5]  = '{1,2,0,0, 0, 0,4'b0000,2'd2,2'd2,5'd0};
        tbl[6]  = '{1,2,5,7, 0, 0,4'b0000,2'd2,2'd2,5'd0};
        tbl[7]  = '{0,3,0,0, 1, 0,4'b0000,2'd2,2'd2,5'd0};
        tbl[8]  = '{0,3,0,0, 0, 1,4'b0010,2'd1,2'd1,5'd1};
        tbl[9]  = '{0,3,0,0, 0, 0,4'b0000,2'd1,2'd1,5'd1};
        tbl[10] = '{0,3,0,4, 1, 0,4'b0000,2'd1,2'd1,5'd1};
        tbl[11] = '{0,0,0,4, 0, 0,4'b0000,2'd1,2'd1,5'd1};
        tbl[12] = '{0,0,0,4, 0, 1,4'b1000,2'd2,2'd3,5'd2};
        tbl[13] = '{0,0,0,0, 1, 0,4'b0000,2'd2,2'd3,5'd2};
        tbl[14] = '{0,0,0,0, 0, 0,4'b0000,2'd2,2'd3,5'd2};
        tbl[15] = '{3,0,0,0, 1, 0,4'b0000,2'd2,2'd3,5'd2};
        tbl[16] = '{0,0,0,0, 0, 0,4'b0000,2'd2,2'd3,5'd2};

        #1;
        chk("reset", 1'b0, 4'b0000, 2'd0, 2'd0, 5'd0);
        tick();
        tick();
        rst = 1'b1;

        for (int i = 0; i < 17; i++) begin
            cmd[0] = tbl[i].c0;
            cmd[1] = tbl[i].c1;
            cmd[2] = tbl[i].c2;
            cmd[3] = tbl[i].c3;
            full   = tbl[i].full;
            tick();
            chk($sformatf("vec%0d", i), tbl[i].wr, tbl[i].ack,
                tbl[i].typ, tbl[i].cpu, tbl[i].id);
        end

        // FIFO full blocks CPU1 for 10 cycles, then one-cycle latency.
        cmd[1] = 3'd3;
        full   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_quiet($sformatf("full_blk%0d", i));
        end
        full = 1'b0;
        tick();
        chk("full_drop", 1'b1, 4'b0010, 2'd1, 2'd1, 5'd3);
        cmd[1] = 3'd0;
        tick();
        tick();

        // All four request; round robin from CPU0 after reset.
        do_reset("rst_rr");
        for (int i = 0; i < 4; i++) cmd[i] = 3'd3;
        for (int n = 0; n < 5; n++)
            grant($sformatf("rr%0d", n), n % 4, 2'd1, 5'(n),
                  (n == 4) ? 3'd0 : 3'd3);
        for (int i = 0; i < 4; i++) cmd[i] = 3'd0;
        tick();
        tick();

        // ID counter wraps after 32 broadcasts.
        do_reset("rst_wrap");
        cmd[2] = 3'd4;
        for (int n = 0; n < 33; n++)
            grant($sformatf("wrap%0d", n), 2, 2'd2, 5'(n % 32),
                  (n == 32) ? 3'd0 : 3'd4);

        // Reset during HOLD aborts; restart at id 0 from CPU0 onward.
        cmd[3] = 3'd3;
        wait_wr("abort_issue", ok);
        if (ok) chk("abort_issue", 1'b1, 4'b1000, 2'd1, 2'd3, 5'd1);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("abort_rst", 1'b0, 4'b0000, 2'd0, 2'd0, 5'd0);
        tick();
        chk("abort_hold0", 1'b0, 4'b0000, 2'd0, 2'd0, 5'd0);
        tick();
        chk("abort_hold1", 1'b0, 4'b0000, 2'd0, 2'd0, 5'd0);
        cmd[1] = 3'd3;
        rst    = 1'b1;
        tick();
        chk("first_after_rst", 1'b1, 4'b0010, 2'd1, 2'd1, 5'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/mesi_isc_breq_arb.md
MESI_ISC_BREQ_ARB -- requirements
Module: mesi_isc_breq_arb

Interface
REQ-001 SHALL have parameter CBUS_CMD_WIDTH, default 3, per-CPU main-bus command width.
REQ-002 SHALL have parameter BROAD_TYPE_WIDTH, default 2, broadcast type width.
REQ-003 SHALL have parameter BROAD_ID_WIDTH, default 5, broadcast transaction ID width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port mbus_cmd_array_i, input, 4*CBUS_CMD_WIDTH bits: CPU k command in bits [3k+2:3k].
REQ-007 SHALL have port fifo_status_full_i, input, 1 bit: high when the broadcast FIFO cannot accept a write next cycle.
REQ-008 SHALL have port mbus_ack_array_o, output, 4 bits: one-hot request acknowledge per CPU.
REQ-009 SHALL have port broad_fifo_wr_o, output, 1 bit: broadcast FIFO write strobe.
REQ-010 SHALL have port broad_type_o, output, BROAD_TYPE_WIDTH bits: 1 = WR, 2 = RD.
REQ-011 SHALL have port broad_cpu_id_o, output, 2 bits: ID of the granted CPU.
REQ-012 SHALL have port broad_id_o, output, BROAD_ID_WIDTH bits: broadcast transaction ID.

Function
REQ-013 SHALL decode commands as 0 NOP, 1 WR, 2 RD, 3 WR_BROAD, 4 RD_BROAD; only 3 and 4 are requests; 1, 2 and 5-7 SHALL be ignored.
REQ-014 SHALL implement FSM IDLE -> ISSUE -> HOLD -> IDLE.
REQ-015 In IDLE, with at least one request and fifo_status_full_i = 0 sampled at an edge, SHALL select a winner and go to ISSUE.
REQ-016 In IDLE with fifo_status_full_i = 1 SHALL stay in IDLE and grant nothing.
REQ-017 SHALL grant round-robin: search starts at pointer P (reset 0); after granting CPU k, P becomes (k+1) mod 4.
REQ-018 In ISSUE (exactly one cycle) SHALL drive broad_fifo_wr_o = 1, mbus_ack_array_o[k] = 1 and all other ack bits 0, broad_type_o = 1 for WR_BROAD or 2 for RD_BROAD, broad_cpu_id_o = k, and broad_id_o = current ID counter.
REQ-019 Grant-to-write latency SHALL be exactly one cycle: request sampled at edge T gives ISSUE outputs during cycle T..T+1.
REQ-020 SHALL increment the ID counter on leaving ISSUE, wrapping from 2^BROAD_ID_WIDTH-1 to 0.
REQ-021 In HOLD SHALL wait until CPU k's command is no longer 3 or 4, then return to IDLE; no new grant SHALL occur in HOLD, even if other CPUs request.
REQ-022 Outside ISSUE, broad_fifo_wr_o and mbus_ack_array_o SHALL be 0; broad_type_o, broad_cpu_id_o and broad_id_o SHALL hold their last values.
REQ-023 fifo_status_full_i asserting during ISSUE or HOLD SHALL NOT cancel the write in progress.
REQ-024 A request withdrawn before sampling in IDLE SHALL NOT be granted.

Reset
REQ-025 While rst = 0, independent of clk: state = IDLE, P = 0, ID counter = 0, all outputs = 0.
REQ-026 Reset asserted during ISSUE or HOLD SHALL abort the transaction with no further write or ack, and SHALL NOT increment the ID.
REQ-027 The first grant SHALL be possible at the first rising edge after rst deasserts.

Structure
REQ-028 Command encodings, broadcast type encodings and the width constants SHALL live in shared package mesi_isc_pkg.
REQ-029 The round-robin priority selection (4 requests plus pointer in, one-hot grant and index out, combinational) SHALL be sub-module mesi_isc_breq_rr.

Verification
REQ-030 Test: after reset, CPU2 cmd = 4 with FIFO not full -> next cycle wr = 1, ack = 4'b0100, type = 2, cpu_id = 2, id = 0; then HOLD until CPU2 cmd = 0.
REQ-031 Test: all four CPUs cmd = 3 and held until acked -> grants in order 0, 1, 2, 3, 0 with ids 0, 1, 2, 3, 4.
REQ-032 Test: full = 1 while CPU1 cmd = 3 -> no wr or ack for 10 cycles; drop full -> write for CPU1 one cycle later.
REQ-033 Test: issue 33 broadcasts -> ids run 0..31 then 0.
REQ-034 Test: assert rst during HOLD for CPU3 -> outputs 0 immediately; next grant after release has id 0 and starts the search at CPU0.
REQ-035 Test: CPU0 cmd = 1 and CPU1 cmd = 2 only -> no write and no ack ever.
